// File: rtl/reg_file_p_if.sv
// Bus bundle for reg_file_p: two registered read ports, one write port and
// the sequential-clear handshake. The DUT uses slave; the driver uses master.
interface reg_file_p_if #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 4
);
  logic [ADDR_W-1:0] read_reg1;
  logic [ADDR_W-1:0] read_reg2;
  logic [DATA_W-1:0] read_data1;
  logic [DATA_W-1:0] read_data2;
  logic [ADDR_W-1:0] write_reg;
  logic [DATA_W-1:0] write_data;
  logic              reg_write;
  logic              clr_start;
  logic              busy;
  logic              clr_done;

  modport slave (
    input  read_reg1, read_reg2, write_reg, write_data, reg_write, clr_start,
    output read_data1, read_data2, busy, clr_done
  );

  modport master (
    output read_reg1, read_reg2, write_reg, write_data, reg_write, clr_start,
    input  read_data1, read_data2, busy, clr_done
  );
endinterface

// File: rtl/reg_file_p.sv
// Two-read/one-write flop register file with write-first reads, optional
// hard-wired zero entry, and a one-entry-per-cycle sequential clear engine.
module reg_file_p #(
  parameter int DATA_W   = 32,
  parameter int ADDR_W   = 4,
  parameter int ZERO_REG = 1
) (
  input  logic         clk,
  input  logic         rst_n,
  reg_file_p_if.slave  bus
);
  localparam int DEPTH = 2 ** ADDR_W;

  typedef enum logic {IDLE, CLEAR} state_t;

  state_t            state_q, state_d;
  logic [ADDR_W-1:0] clr_ptr_q, clr_ptr_d;
  logic              clr_done_q, clr_done_d;
  logic [DATA_W-1:0] mem_q [DEPTH];
  logic [DATA_W-1:0] rd1_q, rd1_d, rd2_q, rd2_d;

  // Single effective write port shared by the bus write and the clear engine.
  logic              we;
  logic [ADDR_W-1:0] waddr;
  logic [DATA_W-1:0] wdata;
  logic [DEPTH-1:0]  wen;

  always_comb begin
    state_d    = state_q;
    clr_ptr_d  = clr_ptr_q;
    clr_done_d = 1'b0;
    we         = 1'b0;
    waddr      = bus.write_reg;
    wdata      = bus.write_data;
    case (state_q)
      IDLE: begin
        we = bus.reg_write && !((ZERO_REG != 0) && (bus.write_reg == '0));
        if (bus.clr_start) begin
          state_d   = CLEAR;
          clr_ptr_d = '0;
        end
      end
      CLEAR: begin
        we    = 1'b1;
        waddr = clr_ptr_q;
        wdata = '0;
        // Stop on the last entry instead of wrapping the pointer.
        if (&clr_ptr_q) begin
          state_d    = IDLE;
          clr_done_d = 1'b1;
        end else begin
          clr_ptr_d = clr_ptr_q + ADDR_W'(1);
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      clr_ptr_q  <= '0;
      clr_done_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      clr_ptr_q  <= clr_ptr_d;
      clr_done_q <= clr_done_d;
    end
  end

  for (genvar gi = 0; gi < DEPTH; gi++) begin : g_wen
    assign wen[gi] = we && (waddr == ADDR_W'(gi));
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
    end else begin
      for (int i = 0; i < DEPTH; i++) begin
        if (wen[i]) mem_q[i] <= wdata;
      end
    end
  end

  // Write-first: a same-edge write (including a clear write) bypasses the array.
  always_comb begin
    rd1_d = mem_q[bus.read_reg1];
    if (we && (waddr == bus.read_reg1)) rd1_d = wdata;
    if ((ZERO_REG != 0) && (bus.read_reg1 == '0)) rd1_d = '0;
    rd2_d = mem_q[bus.read_reg2];
    if (we && (waddr == bus.read_reg2)) rd2_d = wdata;
    if ((ZERO_REG != 0) && (bus.read_reg2 == '0)) rd2_d = '0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd1_q <= '0;
      rd2_q <= '0;
    end else begin
      rd1_q <= rd1_d;
      rd2_q <= rd2_d;
    end
  end

  assign bus.read_data1 = rd1_q;
  assign bus.read_data2 = rd2_q;
  assign bus.busy       = (state_q == CLEAR);
  assign bus.clr_done   = clr_done_q;
endmodule

// File: tb/tb_reg_file_p.sv
// Directed bench for reg_file_p: default, ZERO_REG=0 and 64x32 instances
// driven from one linear sequence with hand-computed expectations.
module tb_reg_file_p;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   n_chk = 0;
  int   n_fail = 0;

  always #5 clk = ~clk;

  reg_file_p_if #(.DATA_W(32), .ADDR_W(4)) ifa ();
  reg_file_p_if #(.DATA_W(32), .ADDR_W(4)) ifn ();
  reg_file_p_if #(.DATA_W(64), .ADDR_W(5)) ifw ();

  reg_file_p #(.DATA_W(32), .ADDR_W(4), .ZERO_REG(1)) dut   (.clk(clk), .rst_n(rst_n), .bus(ifa.slave));
  reg_file_p #(.DATA_W(32), .ADDR_W(4), .ZERO_REG(0)) dut_n (.clk(clk), .rst_n(rst_n), .bus(ifn.slave));
  reg_file_p #(.DATA_W(64), .ADDR_W(5), .ZERO_REG(1)) dut_w (.clk(clk), .rst_n(rst_n), .bus(ifw.slave));

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [31:0] fill_val(input int i);
    return 32'h1000_0000 + 32'(i) * 32'h111;
  endfunction

  initial begin
    #200000;
    $display("FAIL watchdog: observed timeout expected completion");
    $fatal(1, "timeout");
  end

  initial begin
    int cnt;
    int nz;
    int pulses;
    int busy_seen;

    ifa.read_reg1 = '0; ifa.read_reg2 = '0; ifa.write_reg = '0; ifa.write_data = '0;
    ifa.reg_write = 1'b0; ifa.clr_start = 1'b0;
    ifn.read_reg1 = '0; ifn.read_reg2 = '0; ifn.write_reg = '0; ifn.write_data = '0;
    ifn.reg_write = 1'b0; ifn.clr_start = 1'b0;
    ifw.read_reg1 = '0; ifw.read_reg2 = '0; ifw.write_reg = '0; ifw.write_data = '0;
    ifw.reg_write = 1'b0; ifw.clr_start = 1'b0;

    #2;
    check("reset_busy", 64'(ifa.busy), 64'd0);
    check("reset_done", 64'(ifa.clr_done), 64'd0);
    check("reset_rd1", 64'(ifa.read_data1), 64'd0);
    check("reset_rd2", 64'(ifa.read_data2), 64'd0);

    @(negedge clk);
    rst_n = 1'b1;

    // First edge after reset: write entry 5
    ifa.write_reg = 4'd5; ifa.write_data = 32'hDEADBEEF; ifa.reg_write = 1'b1;
    tick();
    ifa.reg_write = 1'b0; ifa.read_reg1 = 4'd5; ifa.read_reg2 = 4'd6;
    tick();
    check("wr5_rd1", 64'(ifa.read_data1), 64'hDEADBEEF);
    check("rd6_rd2", 64'(ifa.read_data2), 64'd0);

    // Same-edge write and read of entry 3: bypass
    ifa.write_reg = 4'd3; ifa.write_data = 32'h1234; ifa.reg_write = 1'b1; ifa.read_reg2 = 4'd3;
    tick();
    check("bypass3", 64'(ifa.read_data2), 64'h1234);
    ifa.reg_write = 1'b0;
    tick();
    check("stored3", 64'(ifa.read_data2), 64'h1234);

    // Entry 0 with and without ZERO_REG
    ifa.write_reg = '0; ifa.write_data = 32'hFFFFFFFF; ifa.reg_write = 1'b1; ifa.read_reg1 = '0;
    ifn.write_reg = '0; ifn.write_data = 32'hFFFFFFFF; ifn.reg_write = 1'b1; ifn.read_reg1 = '0;
    tick();
    check("zero_bypass", 64'(ifa.read_data1), 64'd0);
    check("nz_bypass", 64'(ifn.read_data1), 64'hFFFFFFFF);
    ifa.reg_write = 1'b0; ifn.reg_write = 1'b0;
    tick();
    check("zero_stored", 64'(ifa.read_data1), 64'd0);
    check("nz_stored", 64'(ifn.read_data1), 64'hFFFFFFFF);

    // Fill entries 1..15
    for (int i = 1; i < 16; i++) begin
      ifa.write_reg = 4'(i); ifa.write_data = fill_val(i); ifa.reg_write = 1'b1;
      tick();
    end
    ifa.reg_write = 1'b0; ifa.read_reg1 = 4'd9;
    tick();
    check("fill9", 64'(ifa.read_data1), 64'(fill_val(9)));

    // Write and clear requested together: write lands, then clear starts
    ifa.write_reg = 4'd7; ifa.write_data = 32'hAAAA; ifa.reg_write = 1'b1; ifa.clr_start = 1'b1;
    ifa.read_reg1 = 4'd7;
    tick();
    check("wr_clr_busy", 64'(ifa.busy), 64'd1);
    check("wr_clr_rd7", 64'(ifa.read_data1), 64'hAAAA);
    ifa.reg_write = 1'b0; ifa.clr_start = 1'b0;

    cnt = 0; pulses = 0;
    while (ifa.busy === 1'b1 && cnt < 40) begin
      if (ifa.clr_done === 1'b1) pulses++;
      ifa.reg_write = (cnt == 10);
      ifa.write_reg = 4'd2; ifa.write_data = 32'h5555;
      ifa.clr_start = (cnt == 12);
      if (cnt == 5) begin
        ifa.read_reg1 = 4'd5; ifa.read_reg2 = 4'd8;
      end
      tick();
      cnt++;
      if (cnt == 6) begin
        check("clr_bypass5", 64'(ifa.read_data1), 64'd0);
        check("clr_live8", 64'(ifa.read_data2), 64'(fill_val(8)));
      end
    end
    ifa.reg_write = 1'b0; ifa.clr_start = 1'b0;
    check("clr_busy_cycles", 64'(cnt), 64'd16);
    check("clr_no_early_done", 64'(pulses), 64'd0);
    check("clr_done_pulse", 64'(ifa.clr_done), 64'd1);
    ifa.read_reg1 = '0;
    tick();
    check("clr_done_once", 64'(ifa.clr_done), 64'd0);

    nz = 0;
    for (int i = 0; i < 16; i++) begin
      ifa.read_reg1 = 4'(i);
      tick();
      if (ifa.read_data1 !== 32'd0) nz++;
    end
    check("clr_all_zero", 64'(nz), 64'd0);

    // Async reset mid-clear at clr_ptr = 7
    ifa.write_reg = 4'd12; ifa.write_data = 32'hCAFE; ifa.reg_write = 1'b1;
    tick();
    ifa.reg_write = 1'b0; ifa.read_reg1 = 4'd12; ifa.clr_start = 1'b1;
    tick();
    ifa.clr_start = 1'b0;
    repeat (7) tick();
    check("mid_busy", 64'(ifa.busy), 64'd1);
    check("mid_rd12", 64'(ifa.read_data1), 64'hCAFE);
    #2;
    rst_n = 1'b0;
    #1;
    check("arst_busy", 64'(ifa.busy), 64'd0);
    check("arst_rd1", 64'(ifa.read_data1), 64'd0);
    check("arst_rd2", 64'(ifa.read_data2), 64'd0);
    check("arst_done", 64'(ifa.clr_done), 64'd0);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    pulses = 0; busy_seen = 0;
    repeat (20) begin
      tick();
      if (ifa.clr_done === 1'b1) pulses++;
      if (ifa.busy !== 1'b0) busy_seen++;
    end
    check("post_rst_no_done", 64'(pulses), 64'd0);
    check("post_rst_idle", 64'(busy_seen), 64'd0);
    check("post_rst_rd12", 64'(ifa.read_data1), 64'd0);

    // Wide instance: 64-bit data, 32 entries
    ifw.write_reg = 5'd31; ifw.write_data = 64'h0123456789ABCDEF; ifw.reg_write = 1'b1;
    tick();
    ifw.reg_write = 1'b0; ifw.read_reg1 = 5'd31;
    tick();
    check("wide_rd31", ifw.read_data1, 64'h0123456789ABCDEF);
    ifw.clr_start = 1'b1;
    tick();
    ifw.clr_start = 1'b0;
    cnt = 0;
    while (ifw.busy === 1'b1 && cnt < 80) begin
      tick();
      cnt++;
    end
    check("wide_clr_cycles", 64'(cnt), 64'd32);
    check("wide_clr_done", 64'(ifw.clr_done), 64'd1);
    tick();
    check("wide_rd31_clr", ifw.read_data1, 64'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule

// File: doc/reg_file_p.md
REG_FILE_P -- requirements
Module: reg_file_p

Interface
REQ-001 Parameter DATA_W, default 32, width of each register entry in bits.
REQ-002 Parameter ADDR_W, default 4, address width; DEPTH = 2**ADDR_W entries.
REQ-003 Parameter ZERO_REG, default 1; when 1, entry 0 reads as zero and ignores writes.
REQ-004 clk  input  1  single clock; all state changes on the rising edge.
REQ-005 rst_n  input  1  asynchronous, active-low reset.
REQ-006 read_reg1, read_reg2  input  ADDR_W each  read port addresses, sampled on the clk edge.
REQ-007 read_data1, read_data2  output  DATA_W each  registered read data, valid one cycle after the address is sampled.
REQ-008 write_reg  input  ADDR_W  write address.
REQ-009 write_data  input  DATA_W  write data.
REQ-010 reg_write  input  1  write enable, qualified on the clk edge.
REQ-011 clr_start  input  1  one-cycle request to clear all entries sequentially.
REQ-012 busy  output  1  high while the clear sequence runs.
REQ-013 clr_done  output  1  one-cycle pulse on the cycle the clear completes.

Function
REQ-014 The storage SHALL be a DEPTH x DATA_W flop array, updated only on a rising clk edge, never on data or address changes.
REQ-015 In IDLE, if reg_write=1 on an edge, entry write_reg SHALL take write_data; if ZERO_REG=1 and write_reg=0, the write SHALL be dropped.
REQ-016 Each read port SHALL register array[read_regN] on every edge, giving a latency of one cycle.
REQ-017 Reads SHALL be write-first: when a write and a read target the same entry on the same edge, read_dataN SHALL be the value written on that edge (bypass).
REQ-018 When ZERO_REG=1, read_dataN SHALL be 0 whenever read_regN=0, regardless of any write.
REQ-019 The FSM SHALL have the states IDLE and CLEAR, with a clear pointer clr_ptr of ADDR_W bits.
REQ-020 IDLE -> CLEAR when clr_start=1 on an edge; on that same edge, clr_ptr SHALL be set to 0 and no entry SHALL be cleared yet.
REQ-021 In CLEAR, each edge SHALL zero entry clr_ptr and then increment clr_ptr by 1.
REQ-022 When clr_ptr = DEPTH-1 is cleared, the FSM SHALL return to IDLE and clr_done SHALL be 1 for exactly the following cycle.
REQ-023 A full clear SHALL take DEPTH cycles in CLEAR; clr_ptr SHALL NOT wrap past DEPTH-1.
REQ-024 busy SHALL equal 1 exactly while the state is CLEAR.
REQ-025 In CLEAR, reg_write SHALL be ignored and the write lost; clr_start SHALL be ignored.
REQ-026 If clr_start and reg_write are both 1 in IDLE on the same edge, the write SHALL complete, then the clear SHALL start.
REQ-027 Reads SHALL remain live during CLEAR, and the write-first rule SHALL apply to the clear write: reading entry clr_ptr on its clear edge returns 0.
REQ-028 The output widths SHALL be exactly DATA_W; there is no sign extension or truncation.

Reset
REQ-029 When rst_n=0, all entries, read_data1, read_data2, clr_ptr, busy and clr_done SHALL go to 0 and the state SHALL go to IDLE immediately, without waiting for clk.
REQ-030 Reset asserted mid-clear SHALL abort the sequence with no clr_done pulse; after release the block SHALL be in IDLE.
REQ-031 On the first edge after rst_n rises, the block SHALL accept writes and reads normally.

Verification
REQ-032 Write 0xDEADBEEF to entry 5, then on the next cycle set read_reg1=5 -> read_data1=0xDEADBEEF one cycle later; read_data2 for entry 6 = 0.
REQ-033 On the same edge, write 0x1234 to entry 3 and set read_reg2=3 -> on the next cycle read_data2=0x1234 (bypass).
REQ-034 ZERO_REG=1, write 0xFFFFFFFF to entry 0 -> reading entry 0 returns 0; ZERO_REG=0 -> returns 0xFFFFFFFF.
REQ-035 Fill all 16 entries, pulse clr_start -> busy high for 16 cycles, clr_done pulses once, all entries read 0; a write issued mid-clear is lost.
REQ-036 Drop rst_n low asynchronously between edges at clr_ptr=7 -> busy=0, read_data=0 and state IDLE at once; no clr_done pulse follows.
REQ-037 With ADDR_W=5 and DATA_W=64, write then read entry 31 with 0x0123456789ABCDEF -> exact match, and the clear takes 32 cycles.
